// File: rtl/load_pkg.sv
// Shared types and helpers for the load byte-lane aligner.
// No logic of its own; the enums name funct3 codes and FSM states.
// Helpers are pure functions used combinationally by the aligner.
package load_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ0 = 2'd1,
        READ1 = 2'd2,
        DONE  = 2'd3
    } load_state_e;

    // True for the five RV32I load encodings this unit understands.
    function automatic logic funct3_legal(input logic [2:0] funct3);
        case (funct3)
            LB, LH, LW, LBU, LHU: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    // True when the access spills past the end of the first word.
    function automatic logic crosses_word(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            LH, LHU: return (offset == 2'd3);
            LW:      return (offset != 2'd0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/half/word from {hi,lo} and sign/zero-extends it.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result.
module load_extend
    import load_pkg::*;
(
    input  logic [31:0] lo,
    // The top byte of hi can never reach the result (max shift is 3 bytes),
    // so only hi[23:0] is brought in.
    input  logic [23:0] hi,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] win;

    // Right-shift {hi,lo} by whole bytes according to the address offset.
    always_comb begin
        win = lo;
        case (offset)
            2'd0:    win = lo;
            2'd1:    win = {hi[7:0],  lo[31:8]};
            2'd2:    win = {hi[15:0], lo[31:16]};
            default: win = {hi[23:0], lo[31:24]};
        endcase
    end

    // Size selection and extension; illegal codes yield zero.
    always_comb begin
        result = 32'd0;
        case (funct3)
            LB:      result = {{24{win[7]}}, win[7:0]};
            LH:      result = {{16{win[15]}}, win[15:0]};
            LW:      result = win;
            LBU:     result = {24'd0, win[7:0]};
            LHU:     result = {16'd0, win[15:0]};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_aligner.sv
// Load-side aligner: one or two word reads per request, merged and extended.
// Latency: 3 cycles aligned / 4 split with zero-wait memory, 2 for illegal funct3.
// Accepts only in IDLE (req_ready); response is a one-cycle pulse with no back-pressure.
module load_aligner
    import load_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [width-1:0] req_addr,
    input  logic [2:0]       req_funct3,
    output logic             mem_read,
    output logic [width-1:0] mem_address,
    input  logic [width-1:0] mem_rdata,
    input  logic             mem_resp,
    output logic             rsp_valid,
    output logic [width-1:0] rsp_data,
    output logic             rsp_err
);

    load_state_e state, state_d;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] lo, lo_d;
    logic [31:0] hi, hi_d;
    logic [31:0] ext_result;
    logic [31:0] word0;
    logic        enter_done;

    assign word0 = {addr_q[31:2], 2'b00};

    // Next state and next values of the captured read words.
    always_comb begin
        state_d = state;
        lo_d    = lo;
        hi_d    = hi;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    // Clear both halves so an unused hi reads as zero.
                    lo_d    = 32'd0;
                    hi_d    = 32'd0;
                    state_d = funct3_legal(req_funct3) ? READ0 : DONE;
                end
            end
            READ0: begin
                if (mem_resp) begin
                    lo_d    = mem_rdata;
                    state_d = crosses_word(funct3_q, addr_q[1:0]) ? READ1 : DONE;
                end
            end
            READ1: begin
                if (mem_resp) begin
                    hi_d    = mem_rdata;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_done = (state != DONE) && (state_d == DONE);

    // Fed from the next-values so the result can be registered on the same
    // edge that captures the final read word.
    load_extend u_extend (
        .lo     (lo_d),
        .hi     (hi_d[23:0]),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .result (ext_result)
    );

    // State, request latch, read-word capture and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            lo       <= 32'd0;
            hi       <= 32'd0;
            rsp_data <= 32'd0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_d;
            lo    <= lo_d;
            hi    <= hi_d;
            if (state == IDLE && req_valid) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
            end
            if (enter_done) begin
                if (state == IDLE) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= 32'd0;
                end else begin
                    rsp_err  <= 1'b0;
                    rsp_data <= ext_result;
                end
            end
        end
    end

    // Outputs decode from registered state only; second read wraps mod 2^32.
    assign req_ready   = (state == IDLE);
    assign mem_read    = (state == READ0) || (state == READ1);
    assign mem_address = (state == READ1) ? (word0 + 32'd4) : word0;
    assign rsp_valid   = (state == DONE);

endmodule
